// File: rtl/fwd_operand_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : fwd_operand_stage_if
// Description : Bundles the decode-side inputs, the forwarding-unit match
//               flags and producer results, and the EX-stage outputs of
//               fwd_operand_stage.
//               master : side that drives decode and forwarding inputs
//               slave  : the operand stage itself
// Revision    : 1.0 - initial release
// ============================================================================
interface fwd_operand_stage_if;
  // pipeline control
  logic        stall;
  logic        flush;
  // decode stage
  logic        id_valid;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [31:0] id_rdat1;
  logic [31:0] id_rdat2;
  // forwarding-unit match flags: 1..3 for rs, 4..6 for rt
  logic        forw_en1;
  logic        forw_en2;
  logic        forw_en3;
  logic        forw_en4;
  logic        forw_en5;
  logic        forw_en6;
  // producer results and the retiring write
  logic [31:0] exmem_wdat;
  logic [31:0] memwb_wdat;
  logic [4:0]  memwb_wsel;
  logic        memwb_wen;
  // EX stage outputs
  logic        ex_valid;
  logic [4:0]  ex_rs;
  logic [4:0]  ex_rt;
  logic [31:0] ex_opa;
  logic [31:0] ex_opb;
  logic [4:0]  wb_hist_sel;
  logic [31:0] wb_hist_dat;
  logic [15:0] fwd_cnt;

  modport master (
    output stall, flush, id_valid, id_rs, id_rt, id_rdat1, id_rdat2,
           forw_en1, forw_en2, forw_en3, forw_en4, forw_en5, forw_en6,
           exmem_wdat, memwb_wdat, memwb_wsel, memwb_wen,
    input  ex_valid, ex_rs, ex_rt, ex_opa, ex_opb,
           wb_hist_sel, wb_hist_dat, fwd_cnt
  );

  modport slave (
    input  stall, flush, id_valid, id_rs, id_rt, id_rdat1, id_rdat2,
           forw_en1, forw_en2, forw_en3, forw_en4, forw_en5, forw_en6,
           exmem_wdat, memwb_wdat, memwb_wsel, memwb_wen,
    output ex_valid, ex_rs, ex_rt, ex_opa, ex_opb,
           wb_hist_sel, wb_hist_dat, fwd_cnt
  );
endinterface
`default_nettype wire

// File: rtl/fwd_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : fwd_operand_stage
// Description : ID/EX pipeline register with operand forwarding. Latches the
//               decoded source registers and register-file data, resolves the
//               ALU operands from EX/MEM, MEM/WB or a one-cycle WB history,
//               and counts instructions that consumed a forwarded value.
// Ports       : CLK  - sole clock, rising edge
//               RST  - synchronous active-high reset
//               bus  - fwd_operand_stage_if.slave (decode inputs, forwarding
//                      flags/results, EX outputs, WB history, fwd_cnt)
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_operand_stage (
  input  logic                CLK,
  input  logic                RST,
  fwd_operand_stage_if.slave  bus
);

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  // EX stage state
  logic        ex_valid_q, ex_valid_d;
  logic [4:0]  ex_rs_q,    ex_rs_d;
  logic [4:0]  ex_rt_q,    ex_rt_d;
  logic [31:0] rs_dat_q,   rs_dat_d;
  logic [31:0] rt_dat_q,   rt_dat_d;
  // WB history
  logic [4:0]  hist_sel_q, hist_sel_d;
  logic [31:0] hist_dat_q, hist_dat_d;
  // forwarded-instruction counter
  logic [15:0] cnt_q,      cnt_d;

  // operand resolution
  logic        fwd_a;
  logic        fwd_b;
  logic [31:0] opa;
  logic [31:0] opb;

  // Register 0 is hard-wired zero, so any match on it is ignored.
  always_comb begin
    fwd_a = (ex_rs_q != 5'd0) && (bus.forw_en1 || bus.forw_en2 || bus.forw_en3);
    fwd_b = (ex_rt_q != 5'd0) && (bus.forw_en4 || bus.forw_en5 || bus.forw_en6);

    opa = rs_dat_q;
    if (ex_rs_q != 5'd0) begin
      if (bus.forw_en1)      opa = bus.exmem_wdat;
      else if (bus.forw_en2) opa = bus.memwb_wdat;
      else if (bus.forw_en3) opa = hist_dat_q;
    end

    opb = rt_dat_q;
    if (ex_rt_q != 5'd0) begin
      if (bus.forw_en4)      opb = bus.exmem_wdat;
      else if (bus.forw_en5) opb = bus.memwb_wdat;
      else if (bus.forw_en6) opb = hist_dat_q;
    end
  end

  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_rs_d    = ex_rs_q;
    ex_rt_d    = ex_rt_q;
    rs_dat_d   = rs_dat_q;
    rt_dat_d   = rt_dat_q;
    hist_sel_d = 5'd0;
    hist_dat_d = hist_dat_q;
    cnt_d      = cnt_q;

    if (bus.flush) begin
      ex_valid_d = 1'b0;
      ex_rs_d    = 5'd0;
      ex_rt_d    = 5'd0;
      rs_dat_d   = 32'd0;
      rt_dat_d   = 32'd0;
    end else if (bus.stall) begin
      // Capture the resolved operands so a forwarded value is kept once its
      // producer moves on down the pipe.
      rs_dat_d = opa;
      rt_dat_d = opb;
    end else begin
      ex_valid_d = bus.id_valid;
      ex_rs_d    = bus.id_rs;
      ex_rt_d    = bus.id_rt;
      rs_dat_d   = bus.id_rdat1;
      rt_dat_d   = bus.id_rdat2;
    end

    // History tracks retiring writes independently of stall/flush; a write
    // to register 0 or no write clears the selector but keeps the data.
    if (bus.memwb_wen && (bus.memwb_wsel != 5'd0)) begin
      hist_sel_d = bus.memwb_wsel;
      hist_dat_d = bus.memwb_wdat;
    end

    // Count only instructions that actually leave EX this cycle.
    if (ex_valid_q && !bus.stall && !bus.flush && (fwd_a || fwd_b) &&
        (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ex_valid_q <= 1'b0;
      ex_rs_q    <= 5'd0;
      ex_rt_q    <= 5'd0;
      rs_dat_q   <= 32'd0;
      rt_dat_q   <= 32'd0;
      hist_sel_q <= 5'd0;
      hist_dat_q <= 32'd0;
      cnt_q      <= 16'd0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_rs_q    <= ex_rs_d;
      ex_rt_q    <= ex_rt_d;
      rs_dat_q   <= rs_dat_d;
      rt_dat_q   <= rt_dat_d;
      hist_sel_q <= hist_sel_d;
      hist_dat_q <= hist_dat_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.ex_valid    = ex_valid_q;
  assign bus.ex_rs       = ex_rs_q;
  assign bus.ex_rt       = ex_rt_q;
  assign bus.ex_opa      = opa;
  assign bus.ex_opb      = opb;
  assign bus.wb_hist_sel = hist_sel_q;
  assign bus.wb_hist_dat = hist_dat_q;
  assign bus.fwd_cnt     = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fwd_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fwd_operand_stage
// Description : Scoreboard bench for fwd_operand_stage. The stimulus process
//               drives a cycle, predicts the EX outputs from a behavioural
//               model and queues them; a monitor on the falling edge pops
//               and compares. Random traffic is followed by directed cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fwd_operand_stage;

  typedef struct {
    bit        rst, stall, flush, id_valid;
    bit [4:0]  id_rs, id_rt;
    bit [31:0] rd1, rd2;
    bit [5:0]  en;          // en[0..2] -> forw_en1..3, en[3..5] -> forw_en4..6
    bit [31:0] exmem, memwb;
    bit [4:0]  wsel;
    bit        wen;
  } stim_t;

  typedef struct {
    bit        valid;
    bit [4:0]  rs, rt;
    bit [31:0] opa, opb;
    bit [4:0]  hsel;
    bit [31:0] hdat;
    bit [15:0] cnt;
  } exp_t;

  logic CLK = 1'b0;
  logic RST;
  fwd_operand_stage_if ifc ();

  fwd_operand_stage dut (
    .CLK (CLK),
    .RST (RST),
    .bus (ifc.slave)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_fail = 0;
  exp_t expq[$];

  // behavioural model of the architectural EX state
  bit        m_known = 0;
  bit        m_valid;
  bit [4:0]  m_rs, m_rt;
  bit [31:0] m_d1, m_d2, m_hdat;
  bit [4:0]  m_hsel;
  bit [15:0] m_cnt;

  stim_t     cur;
  bit [32:0] cur_a, cur_b;   // {came_from_forward, value}

  // First enabled source in priority order wins; register 0 takes nothing.
  function automatic bit [32:0] resolve(input bit [4:0] r, input bit [31:0] lat,
                                        input bit [2:0] en, input bit [31:0] s0,
                                        input bit [31:0] s1, input bit [31:0] s2);
    bit [31:0] src [3];
    src[0] = s0; src[1] = s1; src[2] = s2;
    if (r == 5'd0) return {1'b0, lat};
    for (int i = 0; i < 3; i++)
      if (en[i]) return {1'b1, src[i]};
    return {1'b0, lat};
  endfunction

  task automatic cmp(input string name, input bit [31:0] act, input bit [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input stim_t s);
    exp_t e;
    cur = s;
    RST           = s.rst;
    ifc.stall     = s.stall;
    ifc.flush     = s.flush;
    ifc.id_valid  = s.id_valid;
    ifc.id_rs     = s.id_rs;
    ifc.id_rt     = s.id_rt;
    ifc.id_rdat1  = s.rd1;
    ifc.id_rdat2  = s.rd2;
    ifc.forw_en1  = s.en[0];
    ifc.forw_en2  = s.en[1];
    ifc.forw_en3  = s.en[2];
    ifc.forw_en4  = s.en[3];
    ifc.forw_en5  = s.en[4];
    ifc.forw_en6  = s.en[5];
    ifc.exmem_wdat = s.exmem;
    ifc.memwb_wdat = s.memwb;
    ifc.memwb_wsel = s.wsel;
    ifc.memwb_wen  = s.wen;
    cur_a = resolve(m_rs, m_d1, s.en[2:0], s.exmem, s.memwb, m_hdat);
    cur_b = resolve(m_rt, m_d2, s.en[5:3], s.exmem, s.memwb, m_hdat);
    e.valid = m_valid; e.rs = m_rs; e.rt = m_rt;
    e.opa = cur_a[31:0]; e.opb = cur_b[31:0];
    e.hsel = m_hsel; e.hdat = m_hdat; e.cnt = m_cnt;
    if (m_known) expq.push_back(e);
  endtask

  // Advance one clock and move the model forward with the applied inputs.
  task automatic tick();
    @(posedge CLK);
    if (cur.rst) begin
      m_valid = 0; m_rs = 0; m_rt = 0; m_d1 = 0; m_d2 = 0;
      m_hsel = 0; m_hdat = 0; m_cnt = 0; m_known = 1;
    end else begin
      if (m_valid && !cur.stall && !cur.flush && (cur_a[32] || cur_b[32]) && m_cnt != 16'hFFFF)
        m_cnt = m_cnt + 1;
      if (cur.flush) begin
        m_valid = 0; m_rs = 0; m_rt = 0; m_d1 = 0; m_d2 = 0;
      end else if (cur.stall) begin
        m_d1 = cur_a[31:0]; m_d2 = cur_b[31:0];
      end else begin
        m_valid = cur.id_valid; m_rs = cur.id_rs; m_rt = cur.id_rt;
        m_d1 = cur.rd1; m_d2 = cur.rd2;
      end
      if (cur.wen && cur.wsel != 0) begin
        m_hsel = cur.wsel; m_hdat = cur.memwb;
      end else begin
        m_hsel = 0;
      end
    end
    #1;
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{default: 0};
    return s;
  endfunction

  // monitor: compare whatever the stimulus side predicted for this cycle
  always @(negedge CLK) begin
    exp_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      cmp("ex_valid",    {31'd0, ifc.ex_valid}, {31'd0, e.valid});
      cmp("ex_rs",       {27'd0, ifc.ex_rs},    {27'd0, e.rs});
      cmp("ex_rt",       {27'd0, ifc.ex_rt},    {27'd0, e.rt});
      cmp("ex_opa",      ifc.ex_opa,            e.opa);
      cmp("ex_opb",      ifc.ex_opb,            e.opb);
      cmp("wb_hist_sel", {27'd0, ifc.wb_hist_sel}, {27'd0, e.hsel});
      cmp("wb_hist_dat", ifc.wb_hist_dat,       e.hdat);
      cmp("fwd_cnt",     {16'd0, ifc.fwd_cnt},  {16'd0, e.cnt});
    end
  end

  initial begin
    stim_t s;
    bit [15:0] cnt_before;
    int guard;

    // reset
    s = idle(); s.rst = 1;
    apply(s); tick();
    apply(s); #1;
    cmp("rst_opa", ifc.ex_opa, 32'd0);
    cmp("rst_cnt", {16'd0, ifc.fwd_cnt}, 32'd0);
    tick();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      s.rst      = ($urandom_range(0, 63) == 0);
      s.stall    = ($urandom_range(0, 3) == 0);
      s.flush    = ($urandom_range(0, 7) == 0);
      s.id_valid = $urandom_range(0, 1);
      s.id_rs    = 5'($urandom_range(0, 7));
      s.id_rt    = 5'($urandom_range(0, 7));
      s.rd1      = $urandom;
      s.rd2      = $urandom;
      s.en       = 6'($urandom);
      s.exmem    = $urandom;
      s.memwb    = $urandom;
      s.wsel     = 5'($urandom_range(0, 7));
      s.wen      = $urandom_range(0, 1);
      apply(s); tick();
    end

    // load with and without EX/MEM forward
    s = idle(); s.id_valid = 1; s.id_rs = 3; s.rd1 = 32'h11;
    apply(s); tick();
    s.en = 6'b000001; s.exmem = 32'hAA;
    apply(s); #1;
    cmp("load_ex_rs", {27'd0, ifc.ex_rs}, 32'd3);
    cmp("fwd_exmem_opa", ifc.ex_opa, 32'hAA);
    tick();
    s.en = 6'b0;
    apply(s); #1;
    cmp("no_fwd_opa", ifc.ex_opa, 32'h11);
    tick();

    // EX/MEM beats MEM/WB
    s.en = 6'b000011; s.exmem = 32'h1; s.memwb = 32'h2;
    apply(s); #1;
    cmp("prio_opa", ifc.ex_opa, 32'h1);
    tick();

    // stall keeps a forwarded value after its producer leaves
    s = idle(); s.id_valid = 1; s.id_rs = 3; s.stall = 1; s.en = 6'b000010; s.memwb = 32'h55;
    apply(s); #1;
    cmp("stall_fwd_opa", ifc.ex_opa, 32'h55);
    tick();
    s.en = 6'b0; s.memwb = 32'h99;
    apply(s); #1;
    cmp("stall_hold_opa", ifc.ex_opa, 32'h55);
    tick();

    // WB history capture and clear
    s = idle(); s.wen = 1; s.wsel = 7; s.memwb = 32'h77;
    apply(s); tick();
    s = idle();
    apply(s); #1;
    cmp("hist_sel", {27'd0, ifc.wb_hist_sel}, 32'd7);
    cmp("hist_dat", ifc.wb_hist_dat, 32'h77);
    tick();
    apply(s); #1;
    cmp("hist_sel_clr", {27'd0, ifc.wb_hist_sel}, 32'd0);
    tick();

    // flush wins over stall; register 0 never forwarded
    s = idle(); s.id_valid = 1; s.id_rs = 4;
    apply(s); tick();
    cnt_before = m_cnt;
    s.stall = 1; s.flush = 1; s.en = 6'b000001;
    apply(s); tick();
    s = idle(); s.en = 6'b001001; s.exmem = 32'hAB;
    apply(s); #1;
    cmp("flush_valid", {31'd0, ifc.ex_valid}, 32'd0);
    cmp("flush_rs", {27'd0, ifc.ex_rs}, 32'd0);
    cmp("flush_opa_r0", ifc.ex_opa, 32'd0);
    cmp("flush_cnt", {16'd0, ifc.fwd_cnt}, {16'd0, cnt_before});
    tick();

    // counter saturation
    s = idle(); s.id_valid = 1; s.id_rs = 1; s.en = 6'b000001; s.exmem = 32'h5;
    guard = 0;
    while (m_cnt != 16'hFFFE && guard < 70000) begin
      apply(s); tick(); guard++;
    end
    apply(s); #1;
    cmp("cnt_fffe", {16'd0, ifc.fwd_cnt}, 32'h0000FFFE);
    tick();
    apply(s); tick();
    apply(s); #1;
    cmp("cnt_sat", {16'd0, ifc.fwd_cnt}, 32'h0000FFFF);
    tick();
    apply(s); #1;
    cmp("cnt_hold", {16'd0, ifc.fwd_cnt}, 32'h0000FFFF);
    s.rst = 1;
    tick();
    apply(s); tick();
    s = idle();
    apply(s); #1;
    cmp("cnt_rst", {16'd0, ifc.fwd_cnt}, 32'd0);
    tick();

    // let the monitor drain, bounded
    guard = 0;
    while (expq.size() > 0 && guard < 10) begin
      @(posedge CLK); guard++;
    end
    if (expq.size() > 0) begin
      n_chk++; n_fail++;
      $display("FAIL drain: got %0d pending expected 0", expq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fwd_operand_stage.md
FWD_OPERAND_STAGE -- requirements
Module: fwd_operand_stage

Interface
REQ-001 SHALL have port CLK, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port RST, input, 1, reset, synchronous, active-high.
REQ-003 SHALL have ports stall, input, 1, hold EX contents; and flush, input, 1, insert bubble into EX.
REQ-004 SHALL have ports id_valid, input, 1, decode holds a real instruction; and id_rs, id_rt, input, 5 each, decode source register numbers.
REQ-005 SHALL have ports id_rdat1, id_rdat2, input, 32 each, register-file read data for rs/rt.
REQ-006 SHALL have ports forw_en1/2/3, input, 1 each, rs matches EX/MEM, MEM/WB, WB-history write; and forw_en4/5/6, input, 1 each, same three sources for rt.
REQ-007 SHALL have ports exmem_wdat, memwb_wdat, input, 32 each, forwardable results; plus memwb_wsel, input, 5, and memwb_wen, input, 1, retiring write.
REQ-008 SHALL have ports ex_valid, output, 1; and ex_rs, ex_rt, output, 5 each, latched sources driving forwarding-unit read1/read2.
REQ-009 SHALL have ports ex_opa, ex_opb, output, 32 each, resolved ALU operands.
REQ-010 SHALL have ports wb_hist_sel, output, 5, and wb_hist_dat, output, 32, one-cycle WB history driving forwarding-unit write3.
REQ-011 SHALL have port fwd_cnt, output, 16, saturating count of instructions that used forwarding.

Function
REQ-012 Per edge, priority: RST > flush > stall > load.
REQ-013 Load (no stall/flush): ex_valid<=id_valid, ex_rs<=id_rs, ex_rt<=id_rt, latched rs/rt data<=id_rdat1/id_rdat2.
REQ-014 Flush: ex_valid<=0, ex_rs<=0, ex_rt<=0, latched data<=0, regardless of stall.
REQ-015 ex_opa combinational: forw_en1 ? exmem_wdat : forw_en2 ? memwb_wdat : forw_en3 ? wb_hist_dat : latched rs data.
REQ-016 ex_opb identical using forw_en4/5/6 and latched rt data.
REQ-017 Register 0 never forwarded: if ex_rs==0, ex_opa = latched data (0) whatever forw_en1-3; same for ex_rt/forw_en4-6.
REQ-018 Stall: ex_valid, ex_rs, ex_rt held; latched rs/rt data <= current ex_opa/ex_opb, so forwarded values survive producer advancing.
REQ-019 WB history: if memwb_wen && memwb_wsel!=0, wb_hist_sel<=memwb_wsel, wb_hist_dat<=memwb_wdat; else wb_hist_sel<=0, wb_hist_dat held; stall/flush do not affect history.
REQ-020 fwd_cnt +1 on edge where ex_valid && !stall && !flush && any of ex_opa/ex_opb came from a forward source; saturates at 16'hFFFF.
REQ-021 Latency: decode->EX one cycle; operand resolution zero cycles after EX registers.

Reset
REQ-022 RST high at edge: ex_valid=0, ex_rs=0, ex_rt=0, latched data=0, wb_hist_sel=0, wb_hist_dat=0, fwd_cnt=0; overrides stall/flush mid-operation.
REQ-023 During reset, ex_opa/ex_opb SHALL be 0 (all forw_en ignored since ex_rs/ex_rt==0).

Verification
REQ-024 Load id_rs=3, id_rdat1=0x11, forw_en1=1, exmem_wdat=0xAA -> next cycle ex_rs=3, ex_opa=0xAA; forw_en1=0 -> ex_opa=0x11.
REQ-025 forw_en1=forw_en2=1, exmem_wdat=0x1, memwb_wdat=0x2 -> ex_opa=0x1 (EX/MEM priority).
REQ-026 stall=1, forw_en2=1, memwb_wdat=0x55 one cycle, next cycle forw_en=0 and stall still 1 -> ex_opa stays 0x55.
REQ-027 memwb_wen=1, memwb_wsel=7, memwb_wdat=0x77 -> next cycle wb_hist_sel=7, wb_hist_dat=0x77; following cycle memwb_wen=0 -> wb_hist_sel=0.
REQ-028 stall=1 and flush=1 together -> next cycle ex_valid=0, ex_opa=0; fwd_cnt unchanged; ex_rs=0 with forw_en1=1 -> ex_opa=0.
REQ-029 Preload fwd_cnt to 0xFFFE via 2^16-2 forwarded retires, two more -> holds 0xFFFF; RST -> 0.
